appmul_seq_divider: RTL and testbench



---
 rtl/appmul_pkg.sv | 23 ++
 rtl/appmul_seq_divider_div_step.sv | 23 ++
 rtl/appmul_seq_divider.sv | 112 +++++++++++
 tb/tb_appmul_seq_divider.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/appmul_pkg.sv
// Shared constants and state type for the approximate-multiplier companion blocks.
// APPROX_DIV_EN shortens the divider to four iterations on the dividend's upper nibble.
package appmul_pkg;

    localparam int DW = 8;
    localparam int VW = 4;

`ifdef APPROX_DIV_EN
    localparam int ITERS = 4;
`else
    localparam int ITERS = 8;
`endif

    localparam logic [3:0]    LAST_ITER         = 4'(ITERS - 1);
    localparam logic [DW-1:0] ZERO_DIV_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/appmul_seq_divider_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module div_step
    import appmul_pkg::*;
(
    input  logic [VW:0]   shifted,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_next,
    output logic          q_bit
);

    logic [VW:0] wide_divisor;

    assign wide_divisor = {1'b0, divisor};

    always_comb begin
        q_bit    = (shifted >= wide_divisor);
        rem_next = shifted;
        if (q_bit) begin
            rem_next = shifted - wide_divisor;
        end
    end

endmodule

// File: rtl/appmul_seq_divider.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor, valid/ready on both sides.
// Define APPROX_DIV_EN for the truncated 4-iteration variant.
module appmul_seq_divider
    import appmul_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    state_t        state;
    logic [3:0]    iter;
    logic [DW-1:0] dvd_sr;
    logic [DW-1:0] quo_sr;
    logic [VW-1:0] dvs;
    logic [VW:0]   part_rem;

    logic [VW:0]   step_in;
    logic [VW:0]   step_rem;
    logic          step_qbit;
    logic [DW-1:0] quo_next;
    logic [DW-1:0] quo_final;

    assign step_in  = (part_rem << 1) | {{VW{1'b0}}, dvd_sr[DW-1]};
    assign quo_next = (quo_sr << 1) | {{(DW-1){1'b0}}, step_qbit};

    // The truncated build only develops the high quotient nibble; the rest reads as zero.
`ifdef APPROX_DIV_EN
    assign quo_final = {quo_next[ITERS-1:0], {(DW-ITERS){1'b0}}};
`else
    assign quo_final = quo_next;
`endif

    div_step u_step (
        .shifted  (step_in),
        .divisor  (dvs),
        .rem_next (step_rem),
        .q_bit    (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            iter        <= '0;
            dvd_sr      <= '0;
            quo_sr      <= '0;
            dvs         <= '0;
            part_rem    <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_sr   <= dividend;
                        dvs      <= divisor;
                        quo_sr   <= '0;
                        part_rem <= '0;
                        iter     <= '0;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= ZERO_DIV_QUOTIENT;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    part_rem <= step_rem;
                    quo_sr   <= quo_next;
                    dvd_sr   <= dvd_sr << 1;
                    iter     <= iter + 4'd1;
                    if (iter == LAST_ITER) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= quo_final;
                        remainder   <= step_rem[VW-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    // A zero-divisor result enters DONE with out_valid low, giving it one cycle of latency.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_appmul_seq_divider.sv
// Directed self-checking bench for appmul_seq_divider; expectations follow APPROX_DIV_EN when defined.
module tb_appmul_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int nChecks = 0;
    int nFails  = 0;
    int lat;

`ifdef APPROX_DIV_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    always #5 clk = ~clk;

    appmul_seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair and returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b);
        int waited = 0;
        while (!in_ready && waited < 30) begin
            stepCycle();
            waited++;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        stepCycle();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int latency);
        latency = 0;
        while (!out_valid && latency < 40) begin
            stepCycle();
            latency++;
        end
        checkOutput("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'd0;
        divisor   = 4'd0;
        repeat (3) stepCycle();
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        stepCycle();

        // 100 / 7 with five cycles of consumer backpressure and ignored operands
        $display("[TB] 100 / 7 with backpressure");
        applyStimulus(8'd100, 4'd7);
        checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
        waitResult(lat);
        checkOutput("exact_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 8'd9;
            divisor  = 4'd2;
`ifdef APPROX_DIV_EN
            checkOutput("bp_quotient", 32'(quotient), 32'd0);
            checkOutput("bp_remainder", 32'(remainder), 32'd6);
`else
            checkOutput("bp_quotient", 32'(quotient), 32'd14);
            checkOutput("bp_remainder", 32'(remainder), 32'd2);
`endif
            checkOutput("bp_dbz", 32'(div_by_zero), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            stepCycle();
        end
        in_valid = 1'b0;
        releaseResult();
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        repeat (3) stepCycle();
        checkOutput("no_queued_result", 32'(out_valid), 32'd0);

        // zero divisor, with out_ready held high from before acceptance
        $display("[TB] 0xA7 / 0");
        out_ready = 1'b1;
        applyStimulus(8'hA7, 4'd0);
        waitResult(lat);
        checkOutput("zdiv_latency", 32'(lat), 32'd1);
        checkOutput("zdiv_quotient", 32'(quotient), 32'hFF);
        checkOutput("zdiv_remainder", 32'(remainder), 32'h7);
        checkOutput("zdiv_dbz", 32'(div_by_zero), 32'd1);
        stepCycle();
        out_ready = 1'b0;
        checkOutput("zdiv_release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("zdiv_release_in_ready", 32'(in_ready), 32'd1);

        // 200 / 3 distinguishes exact from truncated division
        $display("[TB] 200 / 3");
        applyStimulus(8'd200, 4'd3);
        waitResult(lat);
        checkOutput("d200_latency", 32'(lat), 32'(LAT));
`ifdef APPROX_DIV_EN
        checkOutput("d200_quotient", 32'(quotient), 32'd64);
        checkOutput("d200_remainder", 32'(remainder), 32'd0);
`else
        checkOutput("d200_quotient", 32'(quotient), 32'd66);
        checkOutput("d200_remainder", 32'(remainder), 32'd2);
`endif
        checkOutput("d200_dbz", 32'(div_by_zero), 32'd0);
        releaseResult();

        // reset landing on the fourth iteration of 255 / 1
        $display("[TB] reset during 255 / 1");
        applyStimulus(8'd255, 4'd1);
        repeat (3) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_quotient", 32'(quotient), 32'd0);
        repeat (10) stepCycle();
        checkOutput("midrst_abandoned", 32'(out_valid), 32'd0);

        applyStimulus(8'd255, 4'd1);
        waitResult(lat);
        checkOutput("d255_latency", 32'(lat), 32'(LAT));
`ifdef APPROX_DIV_EN
        checkOutput("d255_quotient", 32'(quotient), 32'hF0);
`else
        checkOutput("d255_quotient", 32'(quotient), 32'd255);
`endif
        checkOutput("d255_remainder", 32'(remainder), 32'd0);
        releaseResult();

`ifndef APPROX_DIV_EN
        $display("[TB] exhaustive sweep of nonzero divisors");
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                applyStimulus(8'(a), 4'(b));
                waitResult(lat);
                checkOutput("sweep_quotient", 32'(quotient), 32'(a / b));
                checkOutput("sweep_remainder", 32'(remainder), 32'(a % b));
                checkOutput("sweep_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                releaseResult();
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
